// File: rtl/fft4_ctrl.sv
// rtl/fft4_ctrl.sv - streaming frame controller wrapping a 4-point FFT pipeline
module fft4_ctrl #(
    parameter int WIDTH  = 24,
    parameter int LAT    = 3,
    parameter int BITREV = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             fft_stall,
    output logic [WIDTH-1:0] fft_x0,
    output logic [WIDTH-1:0] fft_x1,
    output logic [WIDTH-1:0] fft_x2,
    output logic [WIDTH-1:0] fft_x3,
    input  logic [WIDTH-1:0] fft_y0,
    input  logic [WIDTH-1:0] fft_y1,
    input  logic [WIDTH-1:0] fft_y2,
    input  logic [WIDTH-1:0] fft_y3,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   run_cnt;
    logic [WIDTH-1:0] ibuf [4];
    logic [WIDTH-1:0] obuf [4];
    logic [1:0]      wr_idx, rd_idx, rd_sel;
    logic            in_full, out_full;
    logic            accept, pop, launch, load;

    assign accept = in_valid & ~in_full;
    assign pop    = out_full & out_ready;
    // fft4 samples ibuf on the edge that ends the first RUN cycle
    assign launch = (state == RUN) && (run_cnt == '0);
    assign load   = (state == DONE) && !out_full;

    always_comb begin
        state_nx  = state;
        fft_stall = 1'b1;
        case (state)
            IDLE: if (in_full) state_nx = RUN;
            RUN: begin
                fft_stall = 1'b0;
                if (run_cnt == CW'(LAT - 1)) state_nx = DONE;
            end
            DONE: if (!out_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nx;
            run_cnt <= (state == RUN) ? run_cnt + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) ibuf[k] <= '0;
            wr_idx  <= '0;
            in_full <= 1'b0;
        end else if (launch) begin
            in_full <= 1'b0;
            wr_idx  <= '0;
        end else if (accept) begin
            ibuf[wr_idx] <= in_data;
            wr_idx       <= wr_idx + 2'd1;
            if (wr_idx == 2'd3) in_full <= 1'b1;
        end
    end

    // load and pop are exclusive: load needs out_full low, pop needs it high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) obuf[k] <= '0;
            rd_idx    <= '0;
            out_full  <= 1'b0;
            frame_cnt <= '0;
        end else if (load) begin
            obuf[0]   <= fft_y0;
            obuf[1]   <= fft_y1;
            obuf[2]   <= fft_y2;
            obuf[3]   <= fft_y3;
            out_full  <= 1'b1;
            rd_idx    <= '0;
            frame_cnt <= frame_cnt + 16'd1;
        end else if (pop) begin
            rd_idx <= rd_idx + 2'd1;
            if (rd_idx == 2'd3) out_full <= 1'b0;
        end
    end

    assign rd_sel    = (BITREV != 0) ? {rd_idx[0], rd_idx[1]} : rd_idx;
    assign out_data  = obuf[rd_sel];
    assign out_valid = out_full;
    assign out_last  = out_full & (rd_idx == 2'd3);
    assign in_ready  = ~in_full;
    assign busy      = (state != IDLE) | in_full | out_full;
    assign fft_x0    = ibuf[0];
    assign fft_x1    = ibuf[1];
    assign fft_x2    = ibuf[2];
    assign fft_x3    = ibuf[3];

endmodule
